mcht_tx: RTL and testbench

//   Manchester transmitter, 100 MHz domain; sends pMSG_LEN-bit words on TXD for the MCHT_DEC receiver.

---
 rtl/mcht_pkg.sv | 23 ++
 rtl/mcht_half_tmr.sv | 27 ++
 rtl/mcht_tx.sv | 146 ++++++++++++++
 tb/tb_mcht_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mcht_pkg.sv
// Shared types and helpers for the Manchester link.
// Defining MCHT_TX_PARITY_EN adds the ePAR state (even-parity symbol after the payload).
package mcht_pkg;

    localparam int MCHT_HALF_CYC = 4;
    localparam int MCHT_IDLE_MIN = 13;

    typedef enum logic [3:0] {
        eIDLE  = 4'd0,
        eSTART = 4'd1,
        eDATA  = 4'd2,
`ifdef MCHT_TX_PARITY_EN
        ePAR   = 4'd3,
`endif
        eGAP   = 4'd4
    } mcht_tx_st_t;

    // '1' is low-then-high, '0' is high-then-low; half=1 selects the second half.
    function automatic logic mcht_sym(input logic b, input logic half);
        return half ? b : ~b;
    endfunction

endpackage

// File: rtl/mcht_half_tmr.sv
// Loadable down-counter; tc is high while the count sits at zero.
// A load of N gives a segment of N+1 cycles.
module mcht_half_tmr #(
    parameter int pW = 4
) (
    input  logic          CLK100M,
    input  logic          RST_N,
    input  logic          load,
    input  logic [pW-1:0] load_val,
    output logic          tc
);

    logic [pW-1:0] cnt;

    always_ff @(posedge CLK100M or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/mcht_tx.sv
// Manchester transmitter: start symbol, LSB-first payload, enforced high idle gap.
// Optional MCHT_TX_PARITY_EN appends an even-parity symbol before the gap.
//
// state  | meaning
// eIDLE  | line high, TX_RDY high, waiting for accept
// eSTART | start symbol: half low, half high
// eDATA  | payload symbol shadow[idx]
// ePAR   | parity symbol (MCHT_TX_PARITY_EN only)
// eGAP   | line held high; last gap cycle is the eIDLE cycle
module mcht_tx
    import mcht_pkg::*;
#(
    parameter int pMSG_LEN  = 16,
    parameter int pHALF_CYC = MCHT_HALF_CYC,
    parameter int pIDLE_GAP = 16
) (
    input  logic                CLK100M,
    input  logic                RST_N,
    input  logic [pMSG_LEN-1:0] MSG,
    input  logic                TX_VLD,
    output logic                TX_RDY,
    output logic                TXD,
    output logic                BUSY
);

    localparam int IDX_W = $clog2(pMSG_LEN + 1);
    localparam int SEL_W = $clog2(pMSG_LEN);
    localparam int TMR_W = $clog2((pHALF_CYC > pIDLE_GAP) ? pHALF_CYC : pIDLE_GAP);
    localparam logic [TMR_W-1:0] HALF_LD  = TMR_W'(pHALF_CYC - 1);
    // eIDLE supplies the final high cycle, so eGAP itself lasts pIDLE_GAP-1 cycles.
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(pIDLE_GAP - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(pMSG_LEN - 1);

    mcht_tx_st_t          st, st_nxt;
    logic                 half, half_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [pMSG_LEN-1:0]  shadow, shadow_nxt;
    logic                 txd_q, txd_nxt;
    logic                 tmr_ld, tmr_tc;
    logic [TMR_W-1:0]     tmr_val;
    logic [SEL_W-1:0]     bsel;

    mcht_half_tmr #(.pW(TMR_W)) u_tmr (
        .CLK100M  (CLK100M),
        .RST_N    (RST_N),
        .load     (tmr_ld),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge CLK100M or negedge RST_N) begin
        if (!RST_N) begin
            st     <= eIDLE;
            half   <= 1'b0;
            idx    <= '0;
            shadow <= '0;
            txd_q  <= 1'b1;
        end else begin
            st     <= st_nxt;
            half   <= half_nxt;
            idx    <= idx_nxt;
            shadow <= shadow_nxt;
            txd_q  <= txd_nxt;
        end
    end

    always_comb begin
        st_nxt     = st;
        half_nxt   = half;
        idx_nxt    = idx;
        shadow_nxt = shadow;
        tmr_ld     = 1'b0;
        tmr_val    = HALF_LD;
        case (st)
            eIDLE: begin
                if (TX_VLD) begin
                    st_nxt     = eSTART;
                    half_nxt   = 1'b0;
                    idx_nxt    = '0;
                    shadow_nxt = MSG;
                    tmr_ld     = 1'b1;
                end
            end
            eSTART: begin
                if (tmr_tc) begin
                    tmr_ld   = 1'b1;
                    half_nxt = ~half;
                    if (half) st_nxt = eDATA;
                end
            end
            eDATA: begin
                if (tmr_tc) begin
                    tmr_ld   = 1'b1;
                    half_nxt = ~half;
                    if (half) begin
                        idx_nxt = idx + 1'b1;
                        if (idx == IDX_LAST) begin
`ifdef MCHT_TX_PARITY_EN
                            st_nxt  = ePAR;
`else
                            st_nxt  = eGAP;
                            tmr_val = GAP_LD;
`endif
                        end
                    end
                end
            end
`ifdef MCHT_TX_PARITY_EN
            ePAR: begin
                if (tmr_tc) begin
                    tmr_ld   = 1'b1;
                    half_nxt = ~half;
                    if (half) begin
                        st_nxt  = eGAP;
                        tmr_val = GAP_LD;
                    end
                end
            end
`endif
            eGAP: begin
                if (tmr_tc) st_nxt = eIDLE;
            end
            default: st_nxt = eIDLE;
        endcase
    end

    assign bsel = idx_nxt[SEL_W-1:0];

    // Line level is precomputed from the next state so TXD stays a plain flop.
    always_comb begin
        txd_nxt = 1'b1;
        case (st_nxt)
            eSTART:  txd_nxt = half_nxt;
            eDATA:   txd_nxt = mcht_sym(shadow_nxt[bsel], half_nxt);
`ifdef MCHT_TX_PARITY_EN
            ePAR:    txd_nxt = mcht_sym(^shadow_nxt, half_nxt);
`endif
            default: txd_nxt = 1'b1;
        endcase
    end

    assign TXD    = txd_q;
    assign TX_RDY = (st == eIDLE);
    assign BUSY   = (st != eIDLE);

endmodule

// File: tb/tb_mcht_tx.sv
// Bench for mcht_tx: table-driven frames plus random words against a line-level model.
// Honours MCHT_TX_PARITY_EN the same way as the design.
`timescale 1ns/1ps
module tb_mcht_tx;

    localparam int LEN = 16;
    localparam int H   = 4;
    localparam int G   = 16;
`ifdef MCHT_TX_PARITY_EN
    localparam int NB  = LEN + 1;
`else
    localparam int NB  = LEN;
`endif
    localparam int FLEN = (2 + 2 * NB) * H + G;

    logic           CLK100M = 1'b0;
    logic           RST_N   = 1'b0;
    logic           TX_VLD  = 1'b0;
    logic [LEN-1:0] MSG     = '0;
    logic           TX_RDY, TXD, BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    mcht_tx #(.pMSG_LEN(LEN), .pHALF_CYC(H), .pIDLE_GAP(G)) dut (
        .CLK100M (CLK100M),
        .RST_N   (RST_N),
        .MSG     (MSG),
        .TX_VLD  (TX_VLD),
        .TX_RDY  (TX_RDY),
        .TXD     (TXD),
        .BUSY    (BUSY)
    );

    always #5 CLK100M = ~CLK100M;

    typedef struct {
        logic [LEN-1:0] msg;
        bit             hold;
        bit             scramble;
        bit             glitch;
        bit             exp_par;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected line level k cycles after the accept edge (k = 1..FLEN).
    function automatic bit exp_line(input logic [NB-1:0] w, input int k);
        int j;
        int b;
        bit second;
        j = k - 1;
        if (j < H) return 1'b0;
        if (j < 2 * H) return 1'b1;
        j = j - 2 * H;
        if (j < 2 * H * NB) begin
            b      = j / (2 * H);
            second = (j % (2 * H)) >= H;
            return second ? w[b] : ~w[b];
        end
        return 1'b1;
    endfunction

    task automatic run_frame(input string name, input logic [LEN-1:0] msg, input bit hold,
                             input bit scramble, input bit glitch, input logic [NB-1:0] exp_dec);
        logic [NB-1:0] w;
        logic [NB-1:0] dec;
        int            wave_bad;
        bit            line [0:FLEN];
        bit            er;
        w = NB'({^msg, msg});
        check({name, " rdy_before"}, TX_RDY, 1);
        MSG    = msg;
        TX_VLD = 1'b1;
        @(posedge CLK100M);
        @(negedge CLK100M);
        wave_bad = 0;
        for (int k = 1; k <= FLEN; k++) begin
            er      = (k == FLEN);
            line[k] = TXD;
            if (TXD !== exp_line(w, k) || TX_RDY !== er || BUSY !== !er) wave_bad++;
            if (k == 1) begin
                if (!hold) TX_VLD = 1'b0;
                if (scramble) MSG = ~msg;
            end
            if (glitch) TX_VLD = (k == 10 || k == 80);
            if (k < FLEN) @(negedge CLK100M);
        end
        check({name, " bad_cycles"}, wave_bad, 0);
        for (int i = 0; i < NB; i++) dec[i] = line[1 + 2 * H + i * 2 * H + H];
        check({name, " decoded"}, dec, exp_dec);
    endtask

    task automatic idle_check(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge CLK100M);
            if (TXD !== 1'b1 || TX_RDY !== 1'b1 || BUSY !== 1'b0) bad++;
        end
        check({name, " idle_bad"}, bad, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LEN-1:0] m;
        logic [NB-1:0]  rw;
        bit             h;

        vecs[0] = '{16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h8001, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h0007, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h1F00, 1'b0, 1'b1, 1'b0, 1'b1};

        RST_N = 1'b0;
        repeat (3) @(negedge CLK100M);
        check("reset TXD", TXD, 1);
        check("reset TX_RDY", TX_RDY, 1);
        check("reset BUSY", BUSY, 0);
        RST_N = 1'b1;
        @(negedge CLK100M);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].msg, vecs[i].hold, vecs[i].scramble,
                      vecs[i].glitch, NB'({vecs[i].exp_par, vecs[i].msg}));
            if (vecs[i].glitch) idle_check($sformatf("vec%0d", i), 20);
        end

        // Reset at cycle 60 while the line is low (bit 6 first half, bit 6 = 1).
        m      = LEN'($urandom) | 16'h0040;
        rw     = NB'({^m, m});
        MSG    = m;
        TX_VLD = 1'b1;
        @(posedge CLK100M);
        @(negedge CLK100M);
        TX_VLD = 1'b0;
        repeat (59) @(negedge CLK100M);
        check("mid_rst TXD_before", TXD, exp_line(rw, 60));
        check("mid_rst BUSY_before", BUSY, 1);
        #2 RST_N = 1'b0;
        #1;
        check("mid_rst TXD_async", TXD, 1);
        check("mid_rst TX_RDY", TX_RDY, 1);
        check("mid_rst BUSY", BUSY, 0);
        @(negedge CLK100M);
        RST_N = 1'b1;
        @(negedge CLK100M);
        check("post_rst TX_RDY", TX_RDY, 1);
        run_frame("after_rst", 16'h1234, 1'b0, 1'b0, 1'b0, NB'({1'b1, 16'h1234}));

        for (int i = 0; i < 8; i++) begin
            m = LEN'($urandom);
            h = (i < 7) ? bit'($urandom_range(0, 1)) : 1'b0;
            run_frame($sformatf("rnd%0d", i), m, h, bit'($urandom_range(0, 1)), 1'b0,
                      NB'({^m, m}));
        end
        idle_check("final", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
